// File: rtl/top_k_sorter.sv
// top_k_sorter: streaming top-K nearest-neighbour selector.
// Keeps a distance-sorted list of the K best candidates seen for the current
// query. The list has one update per accepted candidate. When the query ends,
// the list is presented with a one-cycle done pulse.
// Entry layout (knn_entry_t, packed): {dist[DIST_W-1:0], id[ID_W-1:0]}.
// Distances are compared as unsigned values.
// Optional feature macro: TOPK_REJECT_CNT_EN adds o_reject_cnt, a per-query
// count of candidates that could not enter a full list.

// One list slot. A slot keeps its entry when the slot's distance is <= the
// candidate's distance. Otherwise it takes either the candidate (when the slot
// above it kept its entry) or the entry of the slot above (a shift down).
module top_k_slot #(
    parameter int DIST_W = 16,
    parameter int ID_W   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_upd,
    input  logic [DIST_W+ID_W-1:0] i_cand,
    input  logic                   i_prev_ge,
    input  logic [DIST_W+ID_W-1:0] i_prev_entry,
    input  logic                   i_prev_valid,
    output logic                   o_ge,
    output logic [DIST_W+ID_W-1:0] o_entry,
    output logic                   o_valid
);
    localparam int EW = DIST_W + ID_W;

    logic [EW-1:0] r_entry;
    logic          r_valid;

    // Slot stays ahead of the candidate: it is occupied and not farther away (stable on ties)
    assign o_ge    = r_valid && (r_entry[EW-1:ID_W] <= i_cand[EW-1:ID_W]);
    assign o_entry = r_entry;
    assign o_valid = r_valid;

    // Slot register: clear on start, otherwise insert or shift when the slot does not hold its place
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_entry <= '0;
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_entry <= '0;
            r_valid <= 1'b0;
        end else if (i_upd && !o_ge) begin
            if (i_prev_ge) begin
                r_entry <= i_cand;
                r_valid <= 1'b1;
            end else begin
                r_entry <= i_prev_entry;
                r_valid <= i_prev_valid;
            end
        end
    end
endmodule

module top_k_sorter #(
    parameter int K      = 8,
    parameter int DIST_W = 16,
    parameter int ID_W   = 16,
    localparam int EW    = DIST_W + ID_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_cand_valid,
    output logic                 o_cand_ready,
    input  logic                 i_cand_last,
    input  logic [EW-1:0]        i_cand_entry,
    output logic [K-1:0][EW-1:0] o_top_k_entry,
    output logic [K-1:0]         o_top_k_valid,
    output logic                 o_top_k_done,
    output logic                 o_busy
`ifdef TOPK_REJECT_CNT_EN
    ,
    output logic [15:0]          o_reject_cnt
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t r_state, w_next;
    logic   w_accept;

    // Slot chains. Index 0 is a virtual slot above the list: it always "keeps",
    // so a candidate better than every occupied slot lands in slot 0.
    logic [K:0]         w_ge;
    logic [K:0][EW-1:0] w_entry;
    logic [K:0]         w_valid;

    assign w_ge[0]    = 1'b1;
    assign w_entry[0] = '0;
    assign w_valid[0] = 1'b0;

    assign w_accept = (r_state == S_COLLECT) && !i_start && i_cand_valid;

    genvar g;
    for (g = 0; g < K; g++) begin : g_slot
        top_k_slot #(.DIST_W(DIST_W), .ID_W(ID_W)) u_slot (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_clr        (i_start),
            .i_upd        (w_accept),
            .i_cand       (i_cand_entry),
            .i_prev_ge    (w_ge[g]),
            .i_prev_entry (w_entry[g]),
            .i_prev_valid (w_valid[g]),
            .o_ge         (w_ge[g+1]),
            .o_entry      (w_entry[g+1]),
            .o_valid      (w_valid[g+1])
        );
        assign o_top_k_entry[g] = w_entry[g+1];
    end

    assign o_top_k_valid = w_valid[K:1];

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and status outputs; start restarts collection from any state
    always_comb begin
        w_next       = r_state;
        o_cand_ready = 1'b0;
        o_busy       = 1'b0;
        o_top_k_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_COLLECT;
            end
            S_COLLECT: begin
                o_busy       = 1'b1;
                o_cand_ready = !i_start;
                if (i_start)                       w_next = S_COLLECT;
                else if (w_accept && i_cand_last)  w_next = S_DONE;
            end
            S_DONE: begin
                o_top_k_done = 1'b1;
                w_next       = i_start ? S_COLLECT : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef TOPK_REJECT_CNT_EN
    logic [15:0] r_reject_cnt;

    // A candidate is rejected when every slot (the list is full) keeps its place
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_reject_cnt <= '0;
        else if (i_start)
            r_reject_cnt <= '0;
        else if (w_accept && w_ge[K] && (r_reject_cnt != 16'hFFFF))
            r_reject_cnt <= r_reject_cnt + 16'd1;
    end

    assign o_reject_cnt = r_reject_cnt;
`endif
endmodule

// File: tb/tb_top_k_sorter.sv
// Bench for top_k_sorter (K=4, 8-bit distance, 8-bit id). It uses a fixed
// vector table, random queries checked against a sort-based reference, and
// hand sequences for abort, start-in-DONE, idle backpressure and async reset.
module tb_top_k_sorter;
    localparam int K  = 4;
    localparam int DW = 8;
    localparam int IW = 8;
    localparam int EW = DW + IW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 cv = 1'b0;
    logic                 cl = 1'b0;
    logic [EW-1:0]        ce = '0;
    logic                 ready, done, busy;
    logic [K-1:0][EW-1:0] tke;
    logic [K-1:0]         tkv;
`ifdef TOPK_REJECT_CNT_EN
    logic [15:0]          rcnt;
`endif

    top_k_sorter #(.K(K), .DIST_W(DW), .ID_W(IW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_cand_valid  (cv),
        .o_cand_ready  (ready),
        .i_cand_last   (cl),
        .i_cand_entry  (ce),
        .o_top_k_entry (tke),
        .o_top_k_valid (tkv),
        .o_top_k_done  (done),
        .o_busy        (busy)
`ifdef TOPK_REJECT_CNT_EN
        ,
        .o_reject_cnt  (rcnt)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int done_cnt = 0;
    int qd[$];
    int qid[$];
    logic [K-1:0][EW-1:0] exp_e;
    logic [K-1:0]         exp_v;
    int                   exp_rej;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        int         n;
        int         d[6];
        int         ed[4];
        int         eid[4];
        logic [3:0] ev;
        int         rej;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cv = 1'b0;
        tick();
        start = 1'b0;
        qd.delete();
        qid.delete();
    endtask

    task automatic beat(input int d, input int id, input bit last);
        cv = 1'b1;
        cl = last;
        ce = {8'(d), 8'(id)};
        qd.push_back(d);
        qid.push_back(id);
        tick();
        cv = 1'b0;
        cl = 1'b0;
        ce = 16'($urandom);
    endtask

    // Reference: the list is the K smallest distances of the query, with earlier
    // arrivals first on ties. A candidate is rejected when at least K earlier
    // candidates are no farther away than it.
    task automatic model();
        bit taken[];
        taken = new[qd.size()];
        exp_e = '0;
        exp_v = '0;
        exp_rej = 0;
        for (int s = 0; s < K; s++) begin
            int best = -1;
            for (int j = 0; j < qd.size(); j++)
                if (!taken[j] && (best < 0 || qd[j] < qd[best])) best = j;
            if (best >= 0) begin
                taken[best] = 1'b1;
                exp_e[s] = {8'(qd[best]), 8'(qid[best])};
                exp_v[s] = 1'b1;
            end
        end
        for (int j = 0; j < qd.size(); j++) begin
            int c = 0;
            for (int i = 0; i < j; i++) if (qd[i] <= qd[j]) c++;
            if (c >= K) exp_rej++;
        end
    endtask

    // Called right after the edge that accepted the last beat
    task automatic check_done(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_list"}, tke, exp_e);
        chk({tag, "_valid"}, 64'(tkv), 64'(exp_v));
`ifdef TOPK_REJECT_CNT_EN
        chk({tag, "_rej"}, 64'(rcnt), 64'(exp_rej));
`endif
        tick();
        @(negedge clk);
        chk({tag, "_pulse_end"}, 64'(done), 64'd0);
        chk({tag, "_held"}, tke, exp_e);
`ifdef TOPK_REJECT_CNT_EN
        chk({tag, "_rej_held"}, 64'(rcnt), 64'(exp_rej));
`endif
    endtask

    task automatic run_vec(input int i);
        do_start();
        for (int j = 0; j < vt[i].n; j++) beat(vt[i].d[j], j + 1, j == vt[i].n - 1);
        exp_v = vt[i].ev;
        exp_rej = vt[i].rej;
        for (int s = 0; s < K; s++) exp_e[s] = {8'(vt[i].ed[s]), 8'(vt[i].eid[s])};
        check_done($sformatf("vec%0d", i));
    endtask

    initial begin
        int d0;
        vt[0] = '{5, '{50, 10, 40, 20, 30, 0}, '{10, 20, 30, 40}, '{2, 4, 5, 3}, 4'b1111, 0};
        vt[1] = '{3, '{5, 5, 5, 0, 0, 0},      '{5, 5, 5, 0},      '{1, 2, 3, 0}, 4'b0111, 0};
        vt[2] = '{5, '{1, 2, 3, 4, 9, 0},      '{1, 2, 3, 4},      '{1, 2, 3, 4}, 4'b1111, 1};
        vt[3] = '{1, '{200, 0, 0, 0, 0, 0},    '{200, 0, 0, 0},    '{1, 0, 0, 0}, 4'b0001, 0};
        vt[4] = '{5, '{3, 3, 3, 3, 3, 0},      '{3, 3, 3, 3},      '{1, 2, 3, 4}, 4'b1111, 1};
        vt[5] = '{6, '{4, 3, 2, 1, 0, 7},      '{0, 1, 2, 3},      '{5, 4, 3, 2}, 4'b1111, 1};

        // Reset state
        #12;
        chk("rst_valid", 64'(tkv), 64'd0);
        chk("rst_list", tke, 64'd0);
        chk("rst_flags", 64'({done, ready, busy}), 64'd0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Random queries against the reference
        for (int q = 0; q < 25; q++) begin
            int n = $urandom_range(1, 9);
            do_start();
            @(negedge clk);
            chk("rand_busy", 64'(busy), 64'd1);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    cv = 1'b0;
                    ce = 16'($urandom);
                    tick();
                end
                beat($urandom_range(0, 15), $urandom_range(0, 255), j == n - 1);
            end
            model();
            check_done($sformatf("rand%0d", q));
        end

        // Idle backpressure: candidate offered in IDLE is not taken
        cv = 1'b1; cl = 1'b1; ce = 16'h0001;
        #1;
        chk("idle_ready", 64'(ready), 64'd0);
        d0 = done_cnt;
        repeat (3) tick();
        @(negedge clk);
        chk("idle_list", tke, exp_e);
        chk("idle_nodone", 64'(done_cnt - d0), 64'd0);
        cv = 1'b0; cl = 1'b0;

        // Candidate offered during DONE is not taken
        do_start();
        beat(10, 1, 0);
        beat(20, 2, 1);
        cv = 1'b1; ce = 16'h0007;
        @(negedge clk);
        chk("done_ready", 64'(ready), 64'd0);
        chk("done_pulse", 64'(done), 64'd1);
        tick();
        @(negedge clk);
        cv = 1'b0;
        chk("after_done_list", tke, {16'h0, 16'h0, 16'h1402, 16'h0A01});
        chk("after_done_valid", 64'(tkv), 64'b0011);

        // Start during DONE still pulses done, then begins a fresh query
        do_start();
        beat(30, 1, 1);
        start = 1'b1;
        @(negedge clk);
        chk("sd_done", 64'(done), 64'd1);
        tick();
        start = 1'b0;
        qd.delete(); qid.delete();
        @(negedge clk);
        chk("sd_busy", 64'(busy), 64'd1);
        chk("sd_cleared", 64'(tkv), 64'd0);
        beat(5, 9, 1);
        model();
        check_done("sd_next");

        // Abort: restart mid-query with a candidate offered alongside start
        do_start();
        beat(7, 1, 0);
        beat(8, 2, 0);
        d0 = done_cnt;
        start = 1'b1; cv = 1'b1; cl = 1'b1; ce = 16'h0163;
        @(negedge clk);
        chk("abort_ready", 64'(ready), 64'd0);
        tick();
        start = 1'b0; cv = 1'b0; cl = 1'b0;
        qd.delete(); qid.delete();
        @(negedge clk);
        chk("abort_cleared", 64'(tkv), 64'd0);
`ifdef TOPK_REJECT_CNT_EN
        chk("abort_rej_clr", 64'(rcnt), 64'd0);
`endif
        beat(3, 1, 1);
        model();
        check_done("abort");
        chk("abort_one_done", 64'(done_cnt - d0), 64'd1);

        // Async reset mid-query
        do_start();
        beat(9, 1, 0);
        beat(4, 2, 0);
        beat(6, 3, 0);
        d0 = done_cnt;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(tkv), 64'd0);
        chk("arst_list", tke, 64'd0);
        chk("arst_flags", 64'({done, ready, busy}), 64'd0);
        @(negedge clk) rst = 1'b1;
        repeat (2) tick();
        chk("arst_nodone", 64'(done_cnt - d0), 64'd0);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/top_k_sorter.md
Name: top_k_sorter

Overview:
- Streaming top-K selector at the producer side of the top-K hand-off.
- Receives candidate knn_entry_t values (distance + point id) from the distance datapath, one per cycle, and keeps a distance-sorted list of the K nearest seen for the current query.
- At end of query, presents the final list on top_k_entry and pulses top_k_done for one cycle. The previous-KNN cache latches the list on that pulse.

Parameters:
- K, default `K: number of nearest neighbours kept. K >= 2.
- DIST_W, default `DIST_W: width of the distance field of knn_entry_t, compared unsigned.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  begin new query; clears list (valid on any state).
- cand_valid  in  1  candidate present.
- cand_ready  out  1  sorter accepts candidate this cycle.
- cand_last  in  1  qualifies cand_valid; final candidate of query.
- cand_entry  in  knn_entry_t  candidate distance + id.
- top_k_entry  out  knn_entry_t [K-1:0]  sorted list, index 0 = nearest.
- top_k_valid  out  K  per-slot occupied flag.
- top_k_done  out  1  one-cycle pulse; list final.
- busy  out  1  query in progress (COLLECT).

Behaviour:
- Reset (rst low, async): state IDLE, all slots zero, top_k_valid=0, top_k_done=0, cand_ready=0, busy=0, occupancy=0.
- FSM states:
  - IDLE: start -> COLLECT.
  - COLLECT: accepted beat with cand_last -> DONE. start -> COLLECT again; list is cleared and no done pulse is produced (abort).
  - DONE: top_k_done=1 for exactly this cycle -> IDLE. start in DONE -> COLLECT; the done pulse is still issued that cycle.
- On start: all slots invalidated, occupancy=0. A cand_valid in the same cycle as start is not accepted.
- Handshake:
  - cand_ready = (state==COLLECT) && !start.
  - Transfer when cand_valid && cand_ready. cand_entry and cand_last are ignored otherwise.
- Insertion, one accepted candidate per cycle, single-cycle update:
  - Parallel compare of cand distance against every valid slot.
  - Insert position p = number of valid slots with dist <= cand dist. Ties keep the earlier arrival ahead (stable).
  - Slots p..K-2 shift down by one; slot K-1 is dropped if it was valid.
  - If occupancy==K and cand dist >= slot[K-1] dist: candidate is rejected and the list is unchanged.
  - Occupancy saturates at K.
- Unsigned DIST_W compare; no arithmetic on distances.
- Latency: last beat accepted in cycle N; list includes it and top_k_done=1 in cycle N+1.
- top_k_entry / top_k_valid are registered, held stable from DONE until the next start.
- Fewer than K candidates: unfilled slots have top_k_valid=0 and entry zero.
- cand_last on a rejected candidate still ends the query.
- Empty query (start then immediate last) still pulses done.
- Reset asserted mid-COLLECT: list discarded, no done pulse.

Optional Feature:
- TOPK_REJECT_CNT_EN
- Defined:
  - Adds output reject_cnt [15:0], counting candidates rejected (full list and not better than slot[K-1]) in the current query.
  - Cleared on start and on reset; saturates at 16'hFFFF; held after DONE.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- K=4: start; feed dists 50,10,40,20,30 (last on 30) -> done pulse 1 cycle after last; list 10,20,30,40, valid=4'b1111.
- Ties, K=4: dists 5(id1),5(id2),5(id3) last -> order id1,id2,id3; valid=4'b0111.
- Reject when full: feed 1,2,3,4 then 9 (last) -> list 1,2,3,4 unchanged; with TOPK_REJECT_CNT_EN, reject_cnt=1.
- Abort: start, feed 7,8, start again, feed 3 last -> exactly one done; list 3, valid=4'b0001.
- Backpressure and idle: cand_valid high in IDLE and DONE -> cand_ready=0, list unchanged; empty query -> done with valid=0.
- Async reset mid-query after 3 beats -> outputs zero immediately; no done pulse; next query behaves normally.
